// File: rtl/xc_malu_mdu_pkg.sv
// Shared constants for the parametrised multiply/divide unit: state encoding,
// op classes, sign modes and the parameter legality check.
package xc_malu_pkg;

  localparam logic [4:0] S_IDLE = 5'b00001;
  localparam logic [4:0] S_MUL  = 5'b00010;
  localparam logic [4:0] S_DIV  = 5'b00100;
  localparam logic [4:0] S_FIX  = 5'b01000;
  localparam logic [4:0] S_DONE = 5'b10000;

  localparam logic OP_MUL = 1'b0;
  localparam logic OP_DIV = 1'b1;

  localparam logic [1:0] SGN_NONE = 2'd0;
  localparam logic [1:0] SGN_RS1  = 2'd1;
  localparam logic [1:0] SGN_BOTH = 2'd2;

  function automatic bit cfg_legal(input int unsigned xlen, input int unsigned bpc);
    return ((xlen == 32) || (xlen == 64)) &&
           ((bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8)) &&
           ((xlen % bpc) == 0);
  endfunction

endpackage

// File: rtl/xc_malu_mdu_if.sv
// Issue/result bundle between the issuing stage and the multiply/divide unit.
interface xc_malu_mdu_if #(parameter int unsigned XLEN = 32);
  logic              flush;
  logic              valid;
  logic              uop_mul;
  logic              uop_mulu;
  logic              uop_mulsu;
  logic              uop_clmul;
  logic              uop_div;
  logic              uop_divu;
  logic              uop_rem;
  logic              uop_remu;
  logic [XLEN-1:0]   rs1;
  logic [XLEN-1:0]   rs2;
  logic              ack;
  logic              busy;
  logic              ready;
  logic [2*XLEN-1:0] result;

  modport master (
    output flush, valid, uop_mul, uop_mulu, uop_mulsu, uop_clmul,
           uop_div, uop_divu, uop_rem, uop_remu, rs1, rs2, ack,
    input  busy, ready, result
  );

  modport slave (
    input  flush, valid, uop_mul, uop_mulu, uop_mulsu, uop_clmul,
           uop_div, uop_divu, uop_rem, uop_remu, rs1, rs2, ack,
    output busy, ready, result
  );
endinterface

// File: rtl/xc_malu_mdu_mulstep.sv
// One multiplier step: folds BPC shifted copies of the multiplicand into the
// accumulator, adding for integer multiply or XORing for carry-less multiply.
module xc_malu_mulstep #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned BPC  = 2
) (
  input  logic [2*XLEN-1:0] acc,
  input  logic [2*XLEN-1:0] mcand,
  input  logic [BPC-1:0]    bits,
  input  logic              clmul,
  output logic [2*XLEN-1:0] acc_nxt_c
);
  always_comb begin
    acc_nxt_c = acc;
    for (int j = 0; j < int'(BPC); j++) begin
      if (bits[j]) begin
        acc_nxt_c = clmul ? (acc_nxt_c ^ (mcand << j)) : (acc_nxt_c + (mcand << j));
      end
    end
  end
endmodule

// File: rtl/xc_malu_mdu.sv
// Multi-cycle multiply/divide unit: shift-add multiplier (MUL_BPC bits/cycle),
// radix-2 restoring divider, sign fix-up, result held until ack.
module xc_malu_mdu
  import xc_malu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned MUL_BPC = 2
) (
  input logic          clock,
  input logic          resetn,
  xc_malu_mdu_if.slave bus
);
  localparam int unsigned N  = XLEN / MUL_BPC;
  localparam int unsigned W2 = 2 * XLEN;
  localparam int unsigned CW = $clog2(XLEN) + 1;

  if (!cfg_legal(XLEN, MUL_BPC)) begin : g_bad_cfg
    $error("xc_malu_mdu: illegal XLEN/MUL_BPC combination");
  end

  logic [4:0]      state, state_nxt;
  logic [W2-1:0]   acc, mcand, result_q, mul_nxt, div_nxt, fix_c;
  logic [XLEN-1:0] opb;
  logic [CW-1:0]   cnt;
  logic            is_clmul, neg_p, neg_q, neg_r;

  // Request decode
  logic [7:0]      uops;
  logic            accept_c, opc_c, div0_c, sneg1_c, sneg2_c;
  logic [1:0]      sgn_c;
  logic [XLEN-1:0] mag1_c, mag2_c;

  assign uops = {bus.uop_mul, bus.uop_mulu, bus.uop_mulsu, bus.uop_clmul,
                 bus.uop_div, bus.uop_divu, bus.uop_rem, bus.uop_remu};
  assign accept_c = (state == S_IDLE) && bus.valid && $onehot(uops);
  assign opc_c = (bus.uop_mul | bus.uop_mulu | bus.uop_mulsu | bus.uop_clmul) ? OP_MUL : OP_DIV;
  assign sgn_c = (bus.uop_mul | bus.uop_div | bus.uop_rem) ? SGN_BOTH :
                 bus.uop_mulsu ? SGN_RS1 : SGN_NONE;
  assign sneg1_c = (sgn_c != SGN_NONE) && bus.rs1[XLEN-1];
  assign sneg2_c = (sgn_c == SGN_BOTH) && bus.rs2[XLEN-1];
  assign mag1_c = sneg1_c ? (XLEN'(0) - bus.rs1) : bus.rs1;
  assign mag2_c = sneg2_c ? (XLEN'(0) - bus.rs2) : bus.rs2;
  assign div0_c = (opc_c == OP_DIV) && (bus.rs2 == XLEN'(0));

  xc_malu_mulstep #(.XLEN(XLEN), .BPC(MUL_BPC)) u_mulstep (
    .acc       (acc),
    .mcand     (mcand),
    .bits      (opb[MUL_BPC-1:0]),
    .clmul     (is_clmul),
    .acc_nxt_c (mul_nxt)
  );

  // Restoring divide step: acc = {remainder, dividend/quotient shift register}
  logic [XLEN:0] rem_sh, diff;
  assign rem_sh = {acc[W2-1:XLEN], acc[XLEN-1]};
  assign diff   = rem_sh - {1'b0, opb};
  assign div_nxt = diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                              : {diff[XLEN-1:0],   acc[XLEN-2:0], 1'b1};

  always_comb begin
    fix_c = acc;
    if (neg_p) begin
      fix_c = W2'(0) - acc;
    end else begin
      if (neg_q) fix_c[XLEN-1:0]  = XLEN'(0) - acc[XLEN-1:0];
      if (neg_r) fix_c[W2-1:XLEN] = XLEN'(0) - acc[W2-1:XLEN];
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (accept_c) state_nxt = (opc_c == OP_MUL) ? S_MUL : (div0_c ? S_FIX : S_DIV);
        S_MUL:  if (cnt == CW'(N - 1))    state_nxt = S_FIX;
        S_DIV:  if (cnt == CW'(XLEN - 1)) state_nxt = S_FIX;
        S_FIX:  state_nxt = S_DONE;
        S_DONE: if (bus.ack) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

  // Datapath; a flushed cycle leaves every register, including result, untouched
  always_ff @(posedge clock) begin
    if (!resetn) begin
      acc      <= '0;
      mcand    <= '0;
      opb      <= '0;
      cnt      <= '0;
      is_clmul <= 1'b0;
      neg_p    <= 1'b0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      result_q <= '0;
    end else if (!bus.flush) begin
      case (state)
        S_IDLE: if (accept_c) begin
          cnt      <= '0;
          is_clmul <= bus.uop_clmul;
          mcand    <= {XLEN'(0), mag1_c};
          opb      <= mag2_c;
          neg_p    <= 1'b0;
          neg_q    <= 1'b0;
          neg_r    <= 1'b0;
          if (opc_c == OP_MUL) begin
            acc   <= '0;
            neg_p <= sneg1_c ^ sneg2_c;
          end else if (div0_c) begin
            acc <= {bus.rs1, {XLEN{1'b1}}};
          end else begin
            acc   <= {XLEN'(0), mag1_c};
            neg_q <= sneg1_c ^ sneg2_c;
            neg_r <= sneg1_c;
          end
        end
        S_MUL: begin
          acc   <= mul_nxt;
          mcand <= mcand << MUL_BPC;
          opb   <= opb >> MUL_BPC;
          cnt   <= cnt + CW'(1);
        end
        S_DIV: begin
          acc <= div_nxt;
          cnt <= cnt + CW'(1);
        end
        S_FIX: result_q <= fix_c;
        default: ;
      endcase
    end
  end

  assign bus.busy   = ~state[0];
  assign bus.ready  = state[4];
  assign bus.result = result_q;

endmodule

// File: tb/tb_xc_malu_mdu.sv
// Directed bench for xc_malu_mdu (XLEN=32, MUL_BPC=2): results, latency,
// zero divisor, flush, reset, ack hold and back-to-back issue.
module tb_xc_malu_mdu;
  localparam logic [7:0] U_MUL   = 8'h80;
  localparam logic [7:0] U_MULU  = 8'h40;
  localparam logic [7:0] U_MULSU = 8'h20;
  localparam logic [7:0] U_CLMUL = 8'h10;
  localparam logic [7:0] U_DIV   = 8'h08;
  localparam logic [7:0] U_DIVU  = 8'h04;

  logic clock = 1'b0;
  logic resetn;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  xc_malu_mdu_if #(.XLEN(32)) bus();

  xc_malu_mdu #(.XLEN(32), .MUL_BPC(2)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  task automatic set_uops(input logic [7:0] u);
    {bus.uop_mul, bus.uop_mulu, bus.uop_mulsu, bus.uop_clmul,
     bus.uop_div, bus.uop_divu, bus.uop_rem, bus.uop_remu} = u;
  endtask

  // Drive one request; return in cycle k+1 with operands scrambled.
  task automatic start(input logic [7:0] u, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    bus.valid = 1'b1; set_uops(u); bus.rs1 = a; bus.rs2 = b;
    @(negedge clock);
    bus.valid = 1'b0; set_uops(8'h00); bus.rs1 = 32'hDEAD_BEEF; bus.rs2 = 32'h0BAD_F00D;
  endtask

  // Cycle index (relative to accept cycle k) in which ready is first seen.
  task automatic issue(input logic [7:0] u, input logic [31:0] a, input logic [31:0] b,
                       output int l);
    start(u, a, b);
    l = 1;
    while (!bus.ready && l < 200) begin
      @(negedge clock);
      l++;
    end
  endtask

  task automatic do_ack();
    bus.ack = 1'b1;
    @(negedge clock);
    bus.ack = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    checks += 3;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b want 0", bus.ready); end
    if (bus.result !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result); end
    resetn = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_mul();
    issue(U_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks += 2;
    if (lat != 18) begin errors++; $display("FAIL mul_latency got %0d want 18", lat); end
    if (bus.result !== 64'h0000_0000_0000_0001) begin errors++; $display("FAIL mul_result got %h want 0000000000000001", bus.result); end
    do_ack();
    checks += 2;
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL ack_ready got %b want 0", bus.ready); end
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL ack_busy got %b want 0", bus.busy); end
    issue(U_MULSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    checks++;
    if (bus.result !== 64'hFFFF_FFFF_0000_0001) begin errors++; $display("FAIL mulsu_result got %h want ffffffff00000001", bus.result); end
    do_ack();
    issue(U_CLMUL, 32'h3, 32'h3, lat);
    checks += 2;
    if (lat != 18) begin errors++; $display("FAIL clmul_latency got %0d want 18", lat); end
    if (bus.result !== 64'h5) begin errors++; $display("FAIL clmul_result got %h want 5", bus.result); end
    do_ack();
  endtask

  task automatic test_div();
    issue(U_DIV, 32'hFFFF_FFF9, 32'h2, lat);
    checks += 2;
    if (lat != 34) begin errors++; $display("FAIL div_latency got %0d want 34", lat); end
    if (bus.result !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL div_neg got %h want fffffffffffffffd", bus.result); end
    do_ack();
    issue(U_DIV, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    checks++;
    if (bus.result !== 64'h0000_0000_8000_0000) begin errors++; $display("FAIL div_overflow got %h want 0000000080000000", bus.result); end
    do_ack();
  endtask

  task automatic test_div0();
    issue(U_DIVU, 32'h5, 32'h0, lat);
    checks += 2;
    if (lat != 2) begin errors++; $display("FAIL div0_latency got %0d want 2", lat); end
    if (bus.result !== 64'h0000_0005_FFFF_FFFF) begin errors++; $display("FAIL div0_result got %h want 00000005ffffffff", bus.result); end
    do_ack();
  endtask

  task automatic test_flush();
    start(U_MUL, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (7) @(negedge clock);
    bus.flush = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0;
    checks += 3;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL flush_busy got %b want 0", bus.busy); end
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b want 0", bus.ready); end
    if (bus.result !== 64'h0000_0005_FFFF_FFFF) begin errors++; $display("FAIL flush_result got %h want 00000005ffffffff", bus.result); end
    issue(U_MULU, 32'h3, 32'h4, lat);
    checks++;
    if (bus.result !== 64'hC) begin errors++; $display("FAIL post_flush_mulu got %h want c", bus.result); end
    bus.flush = 1'b1; bus.ack = 1'b1;
    @(negedge clock);
    bus.flush = 1'b0; bus.ack = 1'b0;
    checks += 2;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin errors++; $display("FAIL flush_ack_idle got busy=%b ready=%b want 0 0", bus.busy, bus.ready); end
    if (bus.result !== 64'hC) begin errors++; $display("FAIL flush_ack_result got %h want c", bus.result); end
  endtask

  task automatic test_back_to_back();
    issue(U_MULU, 32'h1234_5678, 32'h10, lat);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      checks++;
      if (bus.ready !== 1'b1 || bus.result !== 64'h0000_0001_2345_6780) begin
        errors++; $display("FAIL hold_%0d got ready=%b result=%h want 1 0000000123456780", i, bus.ready, bus.result);
      end
    end
    bus.ack = 1'b1;
    @(negedge clock);
    bus.ack = 1'b0;
    bus.valid = 1'b1; set_uops(U_MULU); bus.rs1 = 32'hFFFF_FFFF; bus.rs2 = 32'hFFFF_FFFF;
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_idle got busy=%b want 0", bus.busy); end
    @(negedge clock);
    bus.valid = 1'b0; set_uops(8'h00);
    checks++;
    if (bus.busy !== 1'b1) begin errors++; $display("FAIL b2b_accept got busy=%b want 1", bus.busy); end
    lat = 1;
    while (!bus.ready && lat < 200) begin @(negedge clock); lat++; end
    checks += 2;
    if (lat != 18) begin errors++; $display("FAIL b2b_latency got %0d want 18", lat); end
    if (bus.result !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL b2b_result got %h want fffffffe00000001", bus.result); end
    do_ack();
    bus.valid = 1'b1; set_uops(U_MUL | U_DIV); bus.rs1 = 32'h7; bus.rs2 = 32'h3;
    @(negedge clock);
    bus.valid = 1'b0; set_uops(8'h00);
    repeat (2) @(negedge clock);
    checks += 2;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL two_uops_busy got %b want 0", bus.busy); end
    if (bus.result !== 64'hFFFF_FFFE_0000_0001) begin errors++; $display("FAIL two_uops_result got %h want fffffffe00000001", bus.result); end
  endtask

  task automatic test_reset_midop();
    start(U_MUL, 32'h5, 32'h6);
    repeat (3) @(negedge clock);
    resetn = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    checks += 2;
    if (bus.busy !== 1'b0 || bus.ready !== 1'b0) begin errors++; $display("FAIL midop_reset_state got busy=%b ready=%b want 0 0", bus.busy, bus.ready); end
    if (bus.result !== 64'h0) begin errors++; $display("FAIL midop_reset_result got %h want 0", bus.result); end
  endtask

  initial begin
    resetn = 1'b0;
    bus.flush = 1'b0; bus.valid = 1'b0; bus.ack = 1'b0;
    set_uops(8'h00); bus.rs1 = '0; bus.rs2 = '0;
    test_reset();
    test_mul();
    test_div();
    test_div0();
    test_flush();
    test_back_to_back();
    test_reset_midop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
